config_frame_loader: RTL and testbench
======================================

Name: config_frame_loader

Overview:
- Upstream feeder for the per-row frame data registers of a fabric column.
- Accepts a stream of 32-bit configuration words over a valid/ready handshake, locks on a sync word, and decodes a frame header.
- Distributes one data word per fabric row on FrameData_O with a one-cycle RowSelect_O code, then pulses a one-hot FrameStrobe_O so the selected frame latches the now-stable row registers.

Parameters:
- FrameBitsPerRow, 32, width of a configuration word and of FrameData_O.
- RowSelectWidth, 5, width of RowSelect_O; code 0 = no row selected.
- NumberOfRows, 14, data words per frame; rows addressed 1..NumberOfRows.
- MaxFramesPerCol, 20, width of FrameStrobe_O; valid frame indices 0..MaxFramesPerCol-1.
- FrameSelectWidth, 5, width of the frame-index field in the header word.
- SyncWord, 32'hFAB0_FAB1, stream sync pattern.
- DesyncFlag, 20, header frame index that ends a configuration session.

Ports:
- CLK  input  1  clock, all state on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- WordData_I  input  FrameBitsPerRow  incoming configuration word.
- WordValid_I  input  1  WordData_I valid.
- WordReady_O  output  1  loader can accept a word; transfer when WordValid_I && WordReady_O.
- FrameData_O  output  FrameBitsPerRow  registered row data to all row registers.
- RowSelect_O  output  RowSelectWidth  registered row code, nonzero for exactly one cycle per data word.
- FrameStrobe_O  output  MaxFramesPerCol  registered one-hot frame strobe, one-cycle pulse.
- Busy_O  output  1  1 while synced (state != IDLE).
- Error_O  output  1  sticky bad-header flag.

Behaviour:
- Reset (async, resetn=0): state IDLE, row counter 0, FrameData_O=0, RowSelect_O=0, FrameStrobe_O=0, Error_O=0, Busy_O=0, WordReady_O=1.
- States: IDLE, HEADER, WRITE, STROBE. WordReady_O=1 in IDLE/HEADER/WRITE, 0 in STROBE.
- IDLE:
  - Accepted words other than SyncWord are discarded.
  - SyncWord -> HEADER and clear Error_O.
- HEADER:
  - Frame index = WordData_I[31:32-FrameSelectWidth]; other bits ignored.
  - Word == SyncWord: ignored, stay HEADER.
  - Index == DesyncFlag: -> IDLE, no error.
  - Index >= MaxFramesPerCol (and not DesyncFlag): set Error_O, -> IDLE.
  - Otherwise: latch index, row counter=0, -> WRITE.
- WRITE:
  - Word k (k=0..NumberOfRows-1) accepted at cycle t drives FrameData_O=word and RowSelect_O=k+1 from cycle t+1.
  - RowSelect_O returns to 0 the cycle after unless another word is accepted.
  - FrameData_O holds its last value, never cleared.
  - SyncWord has no special meaning here; it is data.
  - Word NumberOfRows-1 accepted -> STROBE.
- STROBE (one cycle, ready low):
  - FrameStrobe_O[latched index]=1 on the following cycle, for exactly one cycle.
  - That pulse follows the cycle in which RowSelect_O=NumberOfRows, so the last row has latched before the strobe.
  - -> HEADER.
- Gaps in WordValid_I at any point: state holds; no outputs change except RowSelect_O/FrameStrobe_O self-clearing to 0.
- Row counter width = RowSelectWidth; never wraps, since it returns to 0 on each header.
- Reset mid-frame: all state lost immediately; a partial frame produces no FrameStrobe_O.
- Busy_O is registered from state (state != IDLE).

Test Plan:
- Sync 0xFAB0_FAB1, header 0x1800_0000 (index 3), 14 words 0x100..0x10D back-to-back -> RowSelect_O 1..14 on consecutive cycles with matching FrameData_O. WordReady_O low for one cycle. FrameStrobe_O=20'h00008 for one cycle, immediately after RowSelect_O=14.
- Junk words 0x0, 0xDEADBEEF in IDLE -> discarded, Busy_O=0, no RowSelect_O activity. Then sync -> Busy_O=1.
- Header index 25 (0xC800_0000) -> Error_O=1, IDLE, no strobe. Next sync -> Error_O=0.
- Header index 20 (0xA000_0000) after a completed frame -> IDLE, Busy_O=0, Error_O=0.
- WordValid_I toggled 1/0 during WRITE -> RowSelect_O pulses only on accepted words, still 1..14 in order, single strobe at end.
- resetn low after 7 data words -> all outputs 0 asynchronously, no FrameStrobe_O. Data without a new sync -> ignored.

Source files
------------

// File: rtl/config_frame_loader.sv
// Configuration frame loader: locks onto a sync word, decodes a frame header,
// streams one word per fabric row, then pulses a one-hot strobe for the frame.
module config_frame_loader #(
    parameter int                         FrameBitsPerRow  = 32,
    parameter int                         RowSelectWidth   = 5,
    parameter int                         NumberOfRows     = 14,
    parameter int                         MaxFramesPerCol  = 20,
    parameter int                         FrameSelectWidth = 5,
    parameter logic [FrameBitsPerRow-1:0] SyncWord         = 32'hFAB0_FAB1,
    parameter int                         DesyncFlag       = 20
) (
    input  logic                        CLK,
    input  logic                        resetn,
    input  logic [FrameBitsPerRow-1:0]  WordData_I,
    input  logic                        WordValid_I,
    output logic                        WordReady_O,
    output logic [FrameBitsPerRow-1:0]  FrameData_O,
    output logic [RowSelectWidth-1:0]   RowSelect_O,
    output logic [MaxFramesPerCol-1:0]  FrameStrobe_O,
    output logic                        Busy_O,
    output logic                        Error_O
);

    typedef enum logic [1:0] {IDLE, HEADER, WRITE, STROBE} state_t;

    state_t                       state;
    state_t                       next_state;
    logic [RowSelectWidth-1:0]    row_cnt;
    logic [RowSelectWidth-1:0]    row_next;
    logic [RowSelectWidth-1:0]    row_sel_next;
    logic [FrameSelectWidth-1:0]  frame_idx;
    logic [FrameSelectWidth-1:0]  frame_next;
    logic [FrameSelectWidth-1:0]  header_idx;
    logic [FrameBitsPerRow-1:0]   data_next;
    logic [MaxFramesPerCol-1:0]   strobe_next;
    logic                         error_next;
    logic                         accept;
    logic                         is_sync;

    assign WordReady_O = (state != STROBE);
    assign accept      = WordValid_I && WordReady_O;
    assign is_sync     = (WordData_I == SyncWord);
    assign header_idx  = WordData_I[FrameBitsPerRow-1 -: FrameSelectWidth];

    always_comb begin
        next_state   = state;
        row_next     = row_cnt;
        frame_next   = frame_idx;
        data_next    = FrameData_O;
        row_sel_next = '0;
        strobe_next  = '0;
        error_next   = Error_O;

        case (state)
            IDLE: begin
                if (accept && is_sync) begin
                    next_state = HEADER;
                    error_next = 1'b0;
                end
            end
            HEADER: begin
                // A repeated sync word while waiting for a header is just padding.
                if (accept && !is_sync) begin
                    if (32'(header_idx) == DesyncFlag) begin
                        next_state = IDLE;
                    end else if (32'(header_idx) >= MaxFramesPerCol) begin
                        next_state = IDLE;
                        error_next = 1'b1;
                    end else begin
                        frame_next = header_idx;
                        row_next   = '0;
                        next_state = WRITE;
                    end
                end
            end
            WRITE: begin
                if (accept) begin
                    data_next    = WordData_I;
                    row_sel_next = row_cnt + 1'b1;
                    row_next     = row_cnt + 1'b1;
                    if (32'(row_cnt) == NumberOfRows - 1) begin
                        next_state = STROBE;
                    end
                end
            end
            STROBE: begin
                // The last row select is on the outputs now; strobe lands one cycle later.
                strobe_next = MaxFramesPerCol'(1) << frame_idx;
                next_state  = HEADER;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            row_cnt       <= '0;
            frame_idx     <= '0;
            FrameData_O   <= '0;
            RowSelect_O   <= '0;
            FrameStrobe_O <= '0;
            Error_O       <= 1'b0;
            Busy_O        <= 1'b0;
        end else begin
            state         <= next_state;
            row_cnt       <= row_next;
            frame_idx     <= frame_next;
            FrameData_O   <= data_next;
            RowSelect_O   <= row_sel_next;
            FrameStrobe_O <= strobe_next;
            Error_O       <= error_next;
            Busy_O        <= (next_state != IDLE);
        end
    end

endmodule

// File: tb/tb_config_frame_loader.sv
// Directed bench for config_frame_loader: a transaction-level model is compared
// every cycle, and literal expectations pin down the key scenarios.
module tb_config_frame_loader;

    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic        CLK;
    logic        resetn;
    logic [31:0] WordData_I;
    logic        WordValid_I;
    logic        WordReady_O;
    logic [31:0] FrameData_O;
    logic [4:0]  RowSelect_O;
    logic [19:0] FrameStrobe_O;
    logic        Busy_O;
    logic        Error_O;

    int errors = 0;
    int checks = 0;

    config_frame_loader dut (
        .CLK           (CLK),
        .resetn        (resetn),
        .WordData_I    (WordData_I),
        .WordValid_I   (WordValid_I),
        .WordReady_O   (WordReady_O),
        .FrameData_O   (FrameData_O),
        .RowSelect_O   (RowSelect_O),
        .FrameStrobe_O (FrameStrobe_O),
        .Busy_O        (Busy_O),
        .Error_O       (Error_O)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model: synced/in_frame flags, rows written so far, and a pending strobe stall.
    bit          m_synced;
    bit          m_in_frame;
    bit          m_stall;
    bit          m_err;
    int          m_rows;
    int          m_frame;
    int          m_idx;
    logic [31:0] m_data;
    int          m_rs;
    logic [19:0] m_st;

    always @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            m_synced = 0; m_in_frame = 0; m_stall = 0; m_err = 0;
            m_rows = 0; m_frame = 0; m_data = '0; m_rs = 0; m_st = '0;
        end else begin
            m_rs = 0;
            m_st = '0;
            if (m_stall) begin
                m_st    = 20'(1) << m_frame;
                m_stall = 0;
            end else if (WordValid_I) begin
                m_idx = int'(WordData_I >> 27);
                if (!m_synced) begin
                    if (WordData_I == SYNC) begin
                        m_synced = 1;
                        m_err    = 0;
                    end
                end else if (!m_in_frame) begin
                    if (WordData_I == SYNC) begin
                        m_synced = 1;
                    end else if (m_idx == 20) begin
                        m_synced = 0;
                    end else if (m_idx > 19) begin
                        m_synced = 0;
                        m_err    = 1;
                    end else begin
                        m_frame    = m_idx;
                        m_in_frame = 1;
                        m_rows     = 0;
                    end
                end else begin
                    m_data = WordData_I;
                    m_rows = m_rows + 1;
                    m_rs   = m_rows;
                    if (m_rows == 14) begin
                        m_in_frame = 0;
                        m_stall    = 1;
                    end
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Observations used by the literal checks: pulse counts, ordering and strobe timing.
    int          row_pulses  = 0;
    int          order_bad   = 0;
    int          strobe_cnt  = 0;
    int          strobe_late = 0;
    int          ready_low   = 0;
    int          last_row    = 0;
    bit          prev_rs14   = 0;
    logic [19:0] last_strobe = '0;

    always @(negedge CLK) begin
        check_output("ready", 32'(WordReady_O), 32'(!m_stall));
        check_output("data", FrameData_O, m_data);
        check_output("rowsel", 32'(RowSelect_O), 32'(m_rs));
        check_output("strobe", 32'(FrameStrobe_O), 32'(m_st));
        check_output("busy", 32'(Busy_O), 32'(m_synced));
        check_output("error", 32'(Error_O), 32'(m_err));
        if (resetn) begin
            if (RowSelect_O != 0) begin
                row_pulses++;
                if (RowSelect_O != 1 && int'(RowSelect_O) != last_row + 1) order_bad++;
                last_row = int'(RowSelect_O);
            end
            if (FrameStrobe_O != 0) begin
                strobe_cnt++;
                last_strobe = FrameStrobe_O;
                if (!prev_rs14) strobe_late++;
            end
            if (!WordReady_O) ready_low++;
            prev_rs14 = (RowSelect_O == 5'd14);
        end
    end

    task automatic apply_stimulus(input logic [31:0] w);
        int  guard;
        logic took;
        guard = 0;
        WordData_I  = w;
        WordValid_I = 1'b1;
        do begin
            took = WordReady_O;
            @(posedge CLK);
            #1;
            guard++;
        end while (!took && guard < 8);
        if (!took) begin
            errors++;
            checks++;
            $display("[TB] FAIL send_timeout: word 0x%08h not accepted within %0d cycles", w, guard);
        end
    endtask

    task automatic idle_cycles(input int n);
        WordValid_I = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    int rp0, sc0, rl0;

    initial begin
        WordValid_I = 1'b0;
        WordData_I  = '0;
        resetn      = 1'b1;
        #1 resetn   = 1'b0;
        repeat (2) @(posedge CLK);
        #1 resetn = 1'b1;

        $display("[TB] reset state");
        check_output("rst_ready", 32'(WordReady_O), 32'd1);
        check_output("rst_busy", 32'(Busy_O), 32'd0);
        check_output("rst_data", FrameData_O, 32'd0);
        check_output("rst_rowsel", 32'(RowSelect_O), 32'd0);

        $display("[TB] junk words in idle");
        rp0 = row_pulses;
        apply_stimulus(32'h0000_0000);
        apply_stimulus(32'hDEAD_BEEF);
        idle_cycles(2);
        check_output("junk_busy", 32'(Busy_O), 32'd0);
        check_output("junk_rows", 32'(row_pulses - rp0), 32'd0);
        apply_stimulus(SYNC);
        check_output("sync_busy", 32'(Busy_O), 32'd1);

        $display("[TB] back-to-back frame, index 3");
        rp0 = row_pulses; sc0 = strobe_cnt; rl0 = ready_low;
        apply_stimulus(32'h1800_0000);
        for (int i = 0; i < 14; i++) apply_stimulus(32'h100 + 32'(i));
        idle_cycles(3);
        check_output("f1_rows", 32'(row_pulses - rp0), 32'd14);
        check_output("f1_order", 32'(order_bad), 32'd0);
        check_output("f1_strobes", 32'(strobe_cnt - sc0), 32'd1);
        check_output("f1_strobe_val", 32'(last_strobe), 32'h0000_0008);
        check_output("f1_strobe_time", 32'(strobe_late), 32'd0);
        check_output("f1_ready_low", 32'(ready_low - rl0), 32'd1);
        check_output("f1_last_data", FrameData_O, 32'h0000_010D);

        $display("[TB] bad header index 25");
        sc0 = strobe_cnt;
        apply_stimulus(32'hC800_0000);
        idle_cycles(2);
        check_output("bad_err", 32'(Error_O), 32'd1);
        check_output("bad_busy", 32'(Busy_O), 32'd0);
        check_output("bad_strobes", 32'(strobe_cnt - sc0), 32'd0);
        apply_stimulus(SYNC);
        check_output("resync_err", 32'(Error_O), 32'd0);

        $display("[TB] gapped frame, index 7, sync word as data");
        rp0 = row_pulses; sc0 = strobe_cnt;
        apply_stimulus(32'h3800_0000);
        for (int i = 0; i < 14; i++) begin
            apply_stimulus(i == 3 ? SYNC : 32'h200 + 32'(i));
            idle_cycles(1);
        end
        idle_cycles(2);
        check_output("f2_rows", 32'(row_pulses - rp0), 32'd14);
        check_output("f2_order", 32'(order_bad), 32'd0);
        check_output("f2_strobes", 32'(strobe_cnt - sc0), 32'd1);
        check_output("f2_strobe_val", 32'(last_strobe), 32'h0000_0080);
        check_output("f2_strobe_time", 32'(strobe_late), 32'd0);

        $display("[TB] desync header");
        apply_stimulus(32'hA000_0000);
        idle_cycles(1);
        check_output("desync_busy", 32'(Busy_O), 32'd0);
        check_output("desync_err", 32'(Error_O), 32'd0);

        $display("[TB] reset in mid-frame");
        apply_stimulus(SYNC);
        apply_stimulus(32'h0800_0000);
        for (int i = 0; i < 7; i++) apply_stimulus(32'h300 + 32'(i));
        sc0 = strobe_cnt;
        resetn = 1'b0;
        #1;
        check_output("mid_rst_data", FrameData_O, 32'd0);
        check_output("mid_rst_rowsel", 32'(RowSelect_O), 32'd0);
        check_output("mid_rst_busy", 32'(Busy_O), 32'd0);
        check_output("mid_rst_ready", 32'(WordReady_O), 32'd1);
        idle_cycles(2);
        resetn = 1'b1;
        rp0 = row_pulses;
        for (int i = 7; i < 12; i++) apply_stimulus(32'h300 + 32'(i));
        idle_cycles(3);
        check_output("post_rst_busy", 32'(Busy_O), 32'd0);
        check_output("post_rst_rows", 32'(row_pulses - rp0), 32'd0);
        check_output("post_rst_strobes", 32'(strobe_cnt - sc0), 32'd0);
        check_output("post_rst_data", FrameData_O, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
